// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int BAUD_DIV_DEF = 2604;
    localparam int DEPTH_DEF    = 4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Small circular byte FIFO with zero-latency head read.
// Latency: push visible at head one cycle later; pop takes effect on the next edge.
// Backpressure: push into a full FIFO is dropped unless a pop happens in the same cycle.
module rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNTW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNTW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees a slot, so a push into a full FIFO is still taken.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver with majority-vote bit sampling feeding a small byte FIFO.
// Latency: rdy rises about 9.5 bit times + 4 clk after the start-bit falling edge.
// Backpressure: none on the line; a byte arriving at a full FIFO is dropped and flagged.
module uart_rx_buf
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rdy,
    input  logic       clr_rdy,
    output logic       busy,
    output logic       frm_err,
    output logic       ovr_err,
    input  logic       clr_err
);

    localparam int MID = BAUD_DIV / 2;
    localparam int CW  = $clog2(BAUD_DIV);

    rx_state_t   state;
    rx_state_t   state_nxt;
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_prev;
    logic [CW-1:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        smp_a;
    logic        smp_b;
    logic        smp_bit;
    logic        smp_vld;
    logic        stop_bad;
    logic        fall;
    logic        period_end;
    logic        push;
    logic        frm_set;
    logic        ovr_set;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;

    assign fall       = !rx_s2 && rx_prev;
    assign period_end = (baud_cnt == CW'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall) state_nxt = START;
            START: begin
                if (smp_vld && smp_bit) state_nxt = IDLE;
                else if (period_end)    state_nxt = DATA;
            end
            DATA:    if (period_end && bit_cnt == 3'd7) state_nxt = STOP;
            STOP: begin
                // A bad stop bit holds here until the line is back high.
                if (stop_bad) begin
                    if (rx_s2) state_nxt = IDLE;
                end else if (smp_vld && smp_bit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        push    = 1'b0;
        frm_set = 1'b0;
        busy    = (state != IDLE);
        if (state == STOP && smp_vld && !stop_bad) begin
            push    = smp_bit;
            frm_set = !smp_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            smp_a    <= 1'b0;
            smp_b    <= 1'b0;
            smp_bit  <= 1'b0;
            smp_vld  <= 1'b0;
            stop_bad <= 1'b0;
        end else begin
            smp_vld <= 1'b0;
            if (state == IDLE) begin
                // The two synchronizer cycles already belong to the start bit.
                baud_cnt <= fall ? CW'(2) : '0;
                bit_cnt  <= '0;
            end else if (period_end) begin
                baud_cnt <= '0;
                if (state == DATA) bit_cnt <= bit_cnt + 3'd1;
            end else begin
                baud_cnt <= baud_cnt + CW'(1);
            end

            if (state != IDLE) begin
                if (baud_cnt == CW'(MID - 1)) smp_a <= rx_s2;
                if (baud_cnt == CW'(MID))     smp_b <= rx_s2;
                if (baud_cnt == CW'(MID + 1)) begin
                    smp_bit <= maj3(smp_a, smp_b, rx_s2);
                    smp_vld <= 1'b1;
                end
            end

            if (state == DATA && smp_vld) shreg <= {smp_bit, shreg[7:1]};

            if (state != STOP)  stop_bad <= 1'b0;
            else if (frm_set)   stop_bad <= 1'b1;
        end
    end

    assign rdy     = !fifo_empty;
    assign pop     = clr_rdy && !fifo_empty;
    assign ovr_set = push && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            frm_err <= frm_set | (frm_err & ~clr_err);
            ovr_err <= ovr_set | (ovr_err & ~clr_err);
        end
    end

    rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (shreg),
        .pop      (pop),
        .head     (rx_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed bench for uart_rx_buf: a serial driver, a queue-based model of the receive
// FIFO and error flags, a per-cycle compare process, and literal spot checks.
module tb_uart_rx_buf;

    localparam int BD  = 16;
    localparam int DP  = 4;
    localparam int LAT = 9 * BD + BD / 2 + 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RX = 1'b1;
    logic       clr_rdy = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       busy;
    logic       frm_err;
    logic       ovr_err;

    uart_rx_buf #(.BAUD_DIV(BD), .DEPTH(DP)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .rx_data (rx_data),
        .rdy     (rdy),
        .clr_rdy (clr_rdy),
        .busy    (busy),
        .frm_err (frm_err),
        .ovr_err (ovr_err),
        .clr_err (clr_err)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_pass = 0;
    int         cyc    = 0;
    int         start_cyc = 0;
    int         rise_cyc  = -1;
    logic       rdy_q     = 1'b0;
    logic       busy_seen = 1'b0;
    logic       settle    = 1'b0;
    logic [7:0] q[$];
    logic       exp_frm = 1'b0;
    logic       exp_ovr = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Frame outcome from the line protocol alone: good stop -> store unless full.
    task automatic model_frame(input logic [7:0] b, input logic stop_bit);
        if (!stop_bit)           exp_frm = 1'b1;
        else if (q.size() < DP)  q.push_back(b);
        else                     exp_ovr = 1'b1;
    endtask

    task automatic model_pop();
        logic [7:0] tmp;
        if (q.size() != 0) tmp = q.pop_front();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
        @(posedge clk); #1;
        start_cyc = cyc;
        rise_cyc  = -1;
        RX = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            repeat (BD) @(posedge clk);
            #1 RX = b[i];
        end
        if (nbits >= 8) begin
            repeat (BD) @(posedge clk);
            #1 settle = 1'b0;
            RX = stop_bit;
            repeat (BD) @(posedge clk);
            #1 RX = 1'b1;
            model_frame(b, stop_bit);
            settle = 1'b1;
            if (!stop_bit) repeat (4) @(posedge clk);
        end
    endtask

    task automatic pop_byte();
        @(posedge clk); #1 clr_rdy = 1'b1;
        @(posedge clk); #1 clr_rdy = 1'b0;
        model_pop();
    endtask

    task automatic clear_errs();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        exp_frm = 1'b0;
        exp_ovr = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rdy && !rdy_q && rise_cyc < 0) rise_cyc = cyc;
        rdy_q = rdy;
        if (busy) busy_seen = 1'b1;
    end

    always @(negedge clk) begin
        if (settle) begin
            chk("rdy_vs_model", 32'(rdy), 32'(q.size() != 0));
            if (q.size() != 0) chk("head_vs_model", 32'(rx_data), 32'(q[0]));
            chk("frm_vs_model", 32'(frm_err), 32'(exp_frm));
            chk("ovr_vs_model", 32'(ovr_err), 32'(exp_ovr));
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(rdy), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frm", 32'(frm_err), 0);
        chk("rst_ovr", 32'(ovr_err), 0);
        chk("rst_data", 32'(rx_data), 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 settle = 1'b1;

        // Clean frame 0x47 and its latency
        send_frame(8'h47, 1'b1, 8);
        n_chk++;
        if (rise_cyc >= 0 && rise_cyc - start_cyc >= LAT - 1 && rise_cyc - start_cyc <= LAT + 1)
            n_pass++;
        else
            $display("FAIL latency: got %0d cycles expected %0d..%0d", rise_cyc - start_cyc, LAT - 1, LAT + 1);
        chk("b47_data", 32'(rx_data), 32'h47);
        chk("b47_rdy", 32'(rdy), 1);
        pop_byte();
        chk("b47_pop_rdy", 32'(rdy), 0);
        pop_byte();
        chk("pop_empty_rdy", 32'(rdy), 0);

        // Short low pulse: false start
        busy_seen = 1'b0;
        @(posedge clk); #1 RX = 1'b0;
        repeat (5) @(posedge clk);
        #1 RX = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("fs_busy_seen", 32'(busy_seen), 1);
        chk("fs_busy_idle", 32'(busy), 0);
        chk("fs_rdy", 32'(rdy), 0);
        chk("fs_frm", 32'(frm_err), 0);

        // Framing error on 0xA5
        send_frame(8'hA5, 1'b0, 8);
        chk("fe_frm", 32'(frm_err), 1);
        chk("fe_rdy", 32'(rdy), 0);
        clear_errs();
        chk("fe_cleared", 32'(frm_err), 0);

        // Overflow: five frames, no pops
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 8);
        chk("ov_flag", 32'(ovr_err), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("ov_head", 32'(rx_data), 32'(i));
            pop_byte();
        end
        chk("ov_drained", 32'(rdy), 0);
        clear_errs();
        chk("ov_cleared", 32'(ovr_err), 0);

        // Pop on the push cycle with one byte stored
        send_frame(8'h11, 1'b1, 8);
        fork
            send_frame(8'h5A, 1'b1, 8);
            begin
                @(posedge clk);
                repeat (LAT - 1) @(posedge clk);
                #1 clr_rdy = 1'b1;
                @(posedge clk);
                #1 clr_rdy = 1'b0;
                model_pop();
            end
        join
        chk("pp_rdy", 32'(rdy), 1);
        chk("pp_data", 32'(rx_data), 32'h5A);
        pop_byte();
        chk("pp_empty", 32'(rdy), 0);

        // Reset mid-frame with two bytes stored
        send_frame(8'h21, 1'b1, 8);
        send_frame(8'h22, 1'b1, 8);
        send_frame(8'h99, 1'b1, 4);
        repeat (BD / 2) @(posedge clk);
        #1;
        chk("mr_busy", 32'(busy), 1);
        chk("mr_head", 32'(rx_data), 32'h21);
        rst_n = 1'b0;
        q.delete();
        exp_frm = 1'b0;
        exp_ovr = 1'b0;
        RX = 1'b1;
        @(negedge clk);
        chk("mr_rdy", 32'(rdy), 0);
        chk("mr_busy0", 32'(busy), 0);
        chk("mr_data", 32'(rx_data), 0);
        chk("mr_frm", 32'(frm_err), 0);
        chk("mr_ovr", 32'(ovr_err), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        chk("post_rst_rdy", 32'(rdy), 0);
        send_frame(8'h33, 1'b1, 8);
        chk("pr_data", 32'(rx_data), 32'h33);
        chk("pr_rdy", 32'(rdy), 1);
        pop_byte();
        chk("pr_empty", 32'(rdy), 0);

        repeat (5) @(posedge clk);
        settle = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_buf.md
UART_RX_BUF -- requirements
Module: uart_rx_buf

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clk cycles per bit (50 MHz clk, 19200 baud).
REQ-002 Parameter DEPTH, default 4, receive FIFO entries; power of two.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 RX  input  1  serial line, 8N1, LSB first, idle high; asynchronous to clk.
REQ-006 rx_data  output  8  byte at the FIFO head; valid only while rdy=1.
REQ-007 rdy  output  1  FIFO non-empty.
REQ-008 clr_rdy  input  1  pop request; one-cycle pulse consumes the head byte.
REQ-009 busy  output  1  frame reception in progress (state other than IDLE).
REQ-010 frm_err  output  1  sticky; a stop bit was sampled low.
REQ-011 ovr_err  output  1  sticky; a valid byte was dropped because the FIFO was full.
REQ-012 clr_err  input  1  single-cycle pulse clears frm_err and ovr_err.

Function
REQ-013 RX passes through a 2-flop synchronizer before use; both flops are preset to 1.
REQ-014 The state machine has states IDLE, START, DATA, STOP.
REQ-015 IDLE->START: synchronized RX is 0 while the previous synchronized value was 1 (falling edge); the bit counter clears.
REQ-016 Each bit is sampled as a 2-of-3 majority of synchronized RX at baud counts mid-1, mid and mid+1, where mid = BAUD_DIV/2.
REQ-017 START: a majority start sample of 1 is a false start; the machine returns to IDLE with no flag and no push.
REQ-018 START->DATA at the end of the start bit period.
REQ-019 DATA shifts 8 majority samples, LSB first, one per BAUD_DIV period.
REQ-020 After the eighth data bit, DATA->STOP.
REQ-021 STOP, sample 1: the byte is pushed to the FIFO on the cycle after the mid+1 sample, and the machine enters IDLE.
REQ-022 STOP, sample 0: frm_err sets, the byte is discarded, and the machine re-enters IDLE only after synchronized RX returns to 1.
REQ-023 Latency: for a clean frame, rdy rises 9.5 bit times + 4 clk after the RX falling edge (±1 clk).
REQ-024 Push to a full FIFO drops the new byte, sets ovr_err, and leaves the stored contents unchanged.
REQ-025 clr_rdy while rdy=0 is ignored.
REQ-026 A push and a pop in the same cycle are both honoured; the count is unchanged, and the FIFO is not treated as full for that push.
REQ-027 clr_err and an error event in the same cycle: the flag ends set.
REQ-028 FIFO pointers wrap modulo DEPTH; the count ranges 0..DEPTH.
REQ-029 rx_data is driven from the FIFO head combinationally, with zero-latency read.

Reset
REQ-030 rst_n low forces: state IDLE, baud/bit counters 0, shift register 0, FIFO empty, synchronizer flops 1.
REQ-031 During reset: rdy=0, busy=0, frm_err=0, ovr_err=0, rx_data=0.
REQ-032 Reset mid-frame discards the partial byte and all stored bytes.
REQ-033 After reset release, no byte is accepted until a new falling edge follows RX high.

Structure
REQ-034 Shared package uart_pkg holds: rx_state_t enum (IDLE, START, DATA, STOP), the BAUD_DIV default constant, and the DEPTH default constant.
REQ-035 The FIFO is a separate sub-module rx_fifo, with push/pop/full/empty/head ports and its own asynchronous reset.
REQ-036 Top level contains only the synchronizer, the state machine, the counters and the shift register.

Verification
REQ-037 UART_tx sends 0x47 -> rdy rises within the REQ-023 window and rx_data=0x47; clr_rdy pulse -> rdy=0 next cycle.
REQ-038 RX low for 500 clk then high -> busy pulses, then returns to IDLE; rdy=0 and frm_err=0.
REQ-039 Frame 0xA5 with stop bit forced low -> frm_err=1 and rdy=0; clr_err pulse -> frm_err=0.
REQ-040 Bytes 0x01..0x05 sent back-to-back without pops -> ovr_err=1; four pops return 0x01, 0x02, 0x03, 0x04, then rdy=0.
REQ-041 Count=1; clr_rdy asserted on the push cycle of 0x5A -> rdy stays 1 and rx_data=0x5A.
REQ-042 rst_n asserted mid-DATA with 2 bytes stored -> all outputs at reset values; a following 0x33 frame is received correctly.
